// File: rtl/uart_hex_tx.sv
// Prints buffered 16-bit words as ASCII hex lines ("1A2F\r\n") over a
// byte-wide transmitter handshake (data/txen/txempty).
module uart_hex_tx #(
    parameter int FIFO_AW   = 2,
    parameter int UPPERCASE = 1,
    parameter int TERM_CRLF = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_word,
    input  logic        i_wvalid,
    output logic        o_wready,
    input  logic        i_txempty,
    output logic [7:0]  o_data,
    output logic        o_txen,
    output logic        o_busy
);

    // state | meaning
    // IDLE  | no word in progress, waiting for the FIFO to become non-empty
    // SEND  | emitting characters of word_q, one per i_txempty strobe
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [2:0]       LAST_IDX = (TERM_CRLF != 0) ? 3'd5 : 3'd4;

    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] word_q, word_d;
    logic [7:0]  ch;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign o_wready = ~full;
    assign push     = i_wvalid & ~full;
    assign o_busy   = (state_q == SEND) | ~empty;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_word;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return ((UPPERCASE != 0) ? 8'h41 : 8'h61) + {4'h0, nib - 4'd10};
    endfunction

    always_comb begin
        ch = 8'h0A;
        case (idx_q)
            3'd0:    ch = hex_char(word_q[15:12]);
            3'd1:    ch = hex_char(word_q[11:8]);
            3'd2:    ch = hex_char(word_q[7:4]);
            3'd3:    ch = hex_char(word_q[3:0]);
            3'd4:    ch = (TERM_CRLF != 0) ? 8'h0D : 8'h0A;
            default: ch = 8'h0A;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        pop     = 1'b0;
        o_txen  = 1'b0;
        o_data  = 8'h00;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    word_d  = mem[rd_ptr];
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                o_txen = i_txempty;
                o_data = ch;
                if (i_txempty) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        // Chain straight into the next word so lines go out back-to-back.
                        if (!empty) begin
                            pop    = 1'b1;
                            word_d = mem[rd_ptr];
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Scoreboard bench for uart_hex_tx: stimulus queues expected ASCII bytes,
// a monitor pops and compares them on every o_txen strobe.
module tb_uart_hex_tx;

    localparam int BIT_T = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] word_a, word_b;
    logic        wvalid_a, wvalid_b;
    logic        wready_a, wready_b;
    logic        txempty_a, txempty_b;
    logic [7:0]  data_a, data_b;
    logic        txen_a, txen_b;
    logic        busy_a, busy_b;

    int tests;
    int fails;
    int n_a;
    int n_b;
    int mode_a;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    always #5 clk = ~clk;

    uart_hex_tx u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_word(word_a), .i_wvalid(wvalid_a),
        .o_wready(wready_a), .i_txempty(txempty_a), .o_data(data_a),
        .o_txen(txen_a), .o_busy(busy_a)
    );

    uart_hex_tx #(.FIFO_AW(2), .UPPERCASE(0), .TERM_CRLF(0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_word(word_b), .i_wvalid(wvalid_b),
        .o_wready(wready_b), .i_txempty(txempty_b), .o_data(data_b),
        .o_txen(txen_b), .o_busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] hexu(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    task automatic push_word_a(input logic [15:0] w);
        exp_a.push_back(hexu(w[15:12]));
        exp_a.push_back(hexu(w[11:8]));
        exp_a.push_back(hexu(w[7:4]));
        exp_a.push_back(hexu(w[3:0]));
        exp_a.push_back(8'h0D);
        exp_a.push_back(8'h0A);
    endtask

    task automatic wait_idle_a(input int max, input string name);
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (!busy_a) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: busy still high after %0d cycles, required low", name, max);
    endtask

    // Monitor: each strobe hands one byte to the transmitter.
    always @(negedge clk) begin
        if (rst_n) begin
            if (txen_a) begin
                n_a++;
                if (exp_a.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL a_unexpected_byte: got %0h, required no byte", data_a);
                end else begin
                    chk("a_byte", {24'h0, data_a}, {24'h0, exp_a.pop_front()});
                end
            end
            if (txen_b) begin
                n_b++;
                if (exp_b.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL b_unexpected_byte: got %0h, required no byte", data_b);
                end else begin
                    chk("b_byte", {24'h0, data_b}, {24'h0, exp_b.pop_front()});
                end
            end
        end
    end

    // Transmitter model: busy for BIT_T cycles after each accepted byte.
    initial begin : tx_model
        int   cnt;
        logic s;
        cnt = 0;
        forever begin
            @(negedge clk);
            s = txen_a;
            @(posedge clk);
            #1;
            if (mode_a == 2) begin
                if (s) begin
                    txempty_a = 1'b0;
                    cnt = BIT_T;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) txempty_a = 1'b1;
                end
            end
        end
    end

    initial begin : stim
        int base, k, acc_cnt, c_last, c_acc, gaps, s, fell;
        logic acc, prev_txen;
        logic [7:0] prev_data;

        tests = 0; fails = 0; n_a = 0; n_b = 0; mode_a = 0;
        rst_n = 1'b0;
        word_a = '0; word_b = '0; wvalid_a = 1'b0; wvalid_b = 1'b0;
        txempty_a = 1'b1; txempty_b = 1'b1;

        #12;
        chk("rst_wready", {31'h0, wready_a}, 1);
        chk("rst_txen",   {31'h0, txen_a}, 0);
        chk("rst_data",   {24'h0, data_a}, 0);
        chk("rst_busy",   {31'h0, busy_a}, 0);
        chk("rst_b_txen", {31'h0, txen_b}, 0);
        step();
        rst_n = 1'b1;

        // 0x1A2F, CR LF, uppercase, transmitter always idle
        foreach (exp_a[i]) ; // no-op keeps queue untouched
        exp_a.push_back(8'h31); exp_a.push_back(8'h41); exp_a.push_back(8'h32);
        exp_a.push_back(8'h46); exp_a.push_back(8'h0D); exp_a.push_back(8'h0A);
        base = n_a;
        step(); word_a = 16'h1A2F; wvalid_a = 1'b1;
        step(); wvalid_a = 1'b0;
        @(negedge clk);
        chk("t1_txen_during_pop_cycle", {31'h0, txen_a}, 0);
        chk("t1_busy_after_write", {31'h0, busy_a}, 1);
        @(negedge clk);
        chk("t1_first_strobe", {31'h0, txen_a}, 1);
        wait_idle_a(100, "t1_idle");
        chk("t1_byte_count", n_a - base, 6);

        // 0xBEEF, lowercase, LF only
        exp_b.push_back(8'h62); exp_b.push_back(8'h65); exp_b.push_back(8'h65);
        exp_b.push_back(8'h66); exp_b.push_back(8'h0A);
        base = n_b;
        step(); word_b = 16'hBEEF; wvalid_b = 1'b1;
        step(); wvalid_b = 1'b0;
        fell = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy_b) begin fell = 1; break; end
        end
        chk("t2_idle_reached", fell, 1);
        chk("t2_byte_count", n_b - base, 5);

        // Transmitter stalled: fill word register plus FIFO
        step(); txempty_a = 1'b0; k = 1; word_a = 16'(k); wvalid_a = 1'b1; acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = wvalid_a & wready_a;
            step();
            if (acc) begin
                push_word_a(16'(k));
                k++;
                word_a = 16'(k);
                acc_cnt++;
            end
        end
        chk("t3_words_accepted", acc_cnt, 5);
        @(negedge clk);
        chk("t3_wready_full", {31'h0, wready_a}, 0);
        chk("t3_txen_stalled", {31'h0, txen_a}, 0);
        chk("t3_data_held", {24'h0, data_a}, 8'h30);
        chk("t3_busy", {31'h0, busy_a}, 1);

        // Release with i_wvalid still high: last-char pop while full
        step(); txempty_a = 1'b1;
        c_last = -1; c_acc = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            acc = wvalid_a & wready_a;
            if (c_last < 0 && txen_a && data_a == 8'h0A) c_last = c;
            step();
            if (acc) begin
                push_word_a(word_a);
                wvalid_a = 1'b0;
                c_acc = c;
                break;
            end
        end
        chk("t5_accept_after_last_char", c_acc, c_last + 1);
        wait_idle_a(300, "t5_idle");

        // Three words back-to-back through the paced transmitter model
        base = n_a;
        push_word_a(16'h0123); push_word_a(16'hCAFE); push_word_a(16'h7F80);
        step(); mode_a = 2; word_a = 16'h0123; wvalid_a = 1'b1;
        step(); word_a = 16'hCAFE;
        step(); word_a = 16'h7F80;
        step(); wvalid_a = 1'b0;
        gaps = 0; fell = 0; prev_txen = 1'b0; prev_data = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!busy_a) begin
                fell = 1;
                chk("t4_busy_falls_after_last_lf", {23'h0, prev_txen, prev_data}, {23'h0, 1'b1, 8'h0A});
                break;
            end
            if (txempty_a && !txen_a) gaps++;
            prev_txen = txen_a;
            prev_data = data_a;
        end
        chk("t4_busy_fell", fell, 1);
        chk("t4_gap_cycles", gaps, 0);
        chk("t4_byte_count", n_a - base, 18);
        step(); mode_a = 0; txempty_a = 1'b1;

        // Reset during the third character of 0x1234
        exp_a.push_back(8'h31); exp_a.push_back(8'h32); exp_a.push_back(8'h33);
        step(); word_a = 16'h1234; wvalid_a = 1'b1;
        step(); wvalid_a = 1'b0;
        s = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (txen_a) s++;
            if (s == 3) break;
        end
        chk("t6_reached_third_char", s, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_txen", {31'h0, txen_a}, 0);
        chk("t6_rst_data", {24'h0, data_a}, 0);
        chk("t6_rst_wready", {31'h0, wready_a}, 1);
        chk("t6_rst_busy", {31'h0, busy_a}, 0);
        step(); step();
        rst_n = 1'b1;
        exp_a.push_back(8'h30); exp_a.push_back(8'h30); exp_a.push_back(8'h46);
        exp_a.push_back(8'h46); exp_a.push_back(8'h0D); exp_a.push_back(8'h0A);
        base = n_a;
        step(); word_a = 16'h00FF; wvalid_a = 1'b1;
        step(); wvalid_a = 1'b0;
        wait_idle_a(100, "t6_idle");
        chk("t6_byte_count", n_a - base, 6);

        step();
        chk("end_a_queue_empty", exp_a.size(), 0);
        chk("end_b_queue_empty", exp_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
